debug_bus_arbiter: RTL and testbench
====================================

Name: debug_bus_arbiter

Overview:
Shares one debug register bus between two bus masters: the UART-driven debug busmaster (m0) and a second on-chip master such as a test-pattern sequencer (m1). It arbitrates single-beat read/write requests round-robin and issues one strobe per transaction to the slave side. It waits for the slave ack, or a timeout, then returns read data or an error to the granted master. It sits between the masters and the register decode, so that neither master needs to know about the other.

Parameters:
ADDR_W, 16, width of the bus address.
DATA_W, 8, width of read and write data.
TIMEOUT, 255, number of cycles to wait in WAIT_ACK before an error response (must be at least 1).
LOCK_MAX, 16, maximum number of consecutive locked grants to one master while the other master is requesting.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
m0_valid / m1_valid  in  1  request pending; held high until ready
m0_write / m1_write  in  1  1 = write, 0 = read
m0_addr / m1_addr  in  ADDR_W  request address
m0_wdata / m1_wdata  in  DATA_W  write data
m0_lock / m1_lock  in  1  keep the grant for this master's next request
m0_ready / m1_ready  out  1  one-cycle pulse: request accepted
m0_rvalid / m1_rvalid  out  1  one-cycle pulse: transaction complete
m0_rdata / m1_rdata  out  DATA_W  read data, valid while rvalid is high
m0_err / m1_err  out  1  timeout flag, valid while rvalid is high
s_strobe  out  1  one-cycle transaction strobe to the slave
s_write  out  1  registered write flag
s_addr  out  ADDR_W  registered address
s_wdata  out  DATA_W  registered write data
s_ack  in  1  slave completion pulse
s_rdata  in  DATA_W  slave read data, sampled when s_ack is high

Behaviour:
- One clock and a synchronous active-low reset, rst_n, sampled on the rising edge of clk.
- Reset state:
  - FSM in IDLE; all outputs 0.
  - last_grant = 1, so m0 wins the first contention.
  - Lock counter and timeout counter = 0.
  - Reset mid-transaction abandons the transaction silently; the master must re-issue.
- FSM states: IDLE, ISSUE, WAIT_ACK, RESP.
- IDLE:
  - If any valid is high, choose a winner, latch write/addr/wdata/lock and the grant index, then go to ISSUE.
  - With no valid, stay in IDLE.
- Winner selection (applied in this order):
  - Only one valid high: that master wins.
  - Both valid, and the previous grant was locked (its lock was high at latch) with lock_cnt < LOCK_MAX: the previous master wins and lock_cnt increments.
  - Both valid otherwise: the master other than last_grant wins and lock_cnt resets to 0.
  - A grant to a different master, or a grant with lock=0, clears lock_cnt.
  - last_grant updates on every grant.
- ISSUE (exactly 1 cycle):
  - s_strobe = 1 and the granted mX_ready = 1.
  - s_write/s_addr/s_wdata hold the latched values from ISSUE until the next grant.
  - Go to WAIT_ACK and clear the timeout counter.
- WAIT_ACK:
  - s_ack = 1: latch s_rdata (write transactions latch 0) and go to RESP with err = 0.
  - Otherwise increment the timeout counter; when the count reaches TIMEOUT, go to RESP with rdata = 0 and err = 1.
  - s_ack arriving on the same cycle as the timeout is treated as an ack.
- RESP (exactly 1 cycle):
  - The granted master gets rvalid = 1 with its rdata/err. The other master's outputs stay 0.
  - Go to IDLE.
- s_ack outside WAIT_ACK is ignored.
- Throughput: at most one transaction in flight.
- Minimum latency from valid sampled high to rvalid is 4 cycles: IDLE, ISSUE, WAIT_ACK with ack, RESP.
- Back-to-back requests: a master may raise valid for its next request in the cycle after rvalid. That request is sampled in IDLE; there is no bubble beyond IDLE.
- Valid dropped before ready: the request is taken as withdrawn. If it had already been latched in IDLE, the transaction still completes.
- rdata/err outputs are 0 whenever rvalid is low.

Test Plan:
1. Single read: m0 reads addr 0x0012, slave acks 2 cycles after the strobe with 0xA5 -> one s_strobe with s_addr = 0x0012 and s_write = 0; m0_rvalid pulses with rdata = 0xA5 and err = 0; m1 outputs stay 0.
2. Contention round-robin: m0 and m1 hold valid continuously with lock = 0 and the slave acks immediately -> grant order m0, m1, m0, m1; each master sees exactly one ready and one rvalid per request.
3. Lock with starvation cap, LOCK_MAX = 2: m0 lock = 1 streams requests while m1 requests -> grants m0, m0, m0, then m1. m0 gets the initial grant plus 2 locked re-grants before m1 is forced in.
4. Timeout, TIMEOUT = 5: m1 writes 0x3C to 0x0100 and the slave never acks -> m1_rvalid arrives 5 cycles after entering WAIT_ACK with err = 1 and rdata = 0x00; the next m0 request is then served normally.
5. Ack on the timeout cycle, and a stray ack in IDLE -> the first gives err = 0 with the s_rdata value; the second produces no rvalid and no state change.
6. rst_n low during WAIT_ACK -> the next cycle shows all outputs 0 and state IDLE; a later ack is ignored; the first request after reset with both masters valid goes to m0.

Source files
------------

// File: rtl/debug_bus_arbiter.sv
// Two-master round-robin arbiter for the debug register bus.
// Ports: m0_*/m1_* master request/response, s_* single-beat slave side.
module debug_bus_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int TIMEOUT  = 255,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_valid,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_ready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_valid,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_ready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              s_strobe,
  output logic              s_write,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ack,
  input  logic [DATA_W-1:0] s_rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;
  localparam logic [1:0] RESP     = 2'd3;

  logic [1:0]        state;
  logic              gnt;
  logic              last_lock;
  logic [LW-1:0]     lock_cnt;
  logic [TW-1:0]     to_cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              keep;
  logic              win;
  logic              win_lock;
  logic [LW-1:0]     cnt_nxt;

  // gnt doubles as last_grant once the transaction is done.
  always_comb begin
    keep = m0_valid & m1_valid & last_lock
         & (lock_cnt < LW'(LOCK_MAX));
    win  = 1'b0;
    unique case (1'b1)
      (m1_valid & ~m0_valid): win = 1'b1;
      (m0_valid & ~m1_valid): win = 1'b0;
      keep:                   win = gnt;
      default:                win = ~gnt;
    endcase
    win_lock = win ? m1_lock : m0_lock;
    cnt_nxt  = lock_cnt;
    if ((win != gnt) || !win_lock)
      cnt_nxt = '0;
    else if (keep)
      cnt_nxt = lock_cnt + LW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= 1'b1;
      last_lock <= 1'b0;
      lock_cnt  <= '0;
      to_cnt    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      s_write   <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (m0_valid | m1_valid) begin
            state     <= ISSUE;
            gnt       <= win;
            last_lock <= win_lock;
            lock_cnt  <= cnt_nxt;
            s_write   <= win ? m1_write : m0_write;
            s_addr    <= win ? m1_addr  : m0_addr;
            s_wdata   <= win ? m1_wdata : m0_wdata;
          end
        end
        ISSUE: begin
          state  <= WAIT_ACK;
          to_cnt <= '0;
        end
        WAIT_ACK: begin
          // ack wins over a same-cycle timeout
          if (s_ack) begin
            rdata_q <= s_write ? '0 : s_rdata;
            err_q   <= 1'b0;
            state   <= RESP;
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= RESP;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic resp;

  always_comb begin
    s_strobe  = (state == ISSUE);
    resp      = (state == RESP);
    m0_ready  = s_strobe & ~gnt;
    m1_ready  = s_strobe & gnt;
    m0_rvalid = resp & ~gnt;
    m1_rvalid = resp & gnt;
    m0_rdata  = m0_rvalid ? rdata_q : '0;
    m1_rdata  = m1_rvalid ? rdata_q : '0;
    m0_err    = m0_rvalid & err_q;
    m1_err    = m1_rvalid & err_q;
  end

endmodule

// File: tb/tb_debug_bus_arbiter.sv
// Bench for debug_bus_arbiter: directed scenarios then random rounds.
// Grant order is predicted from the arbitration rules at request level.
module tb_debug_bus_arbiter;

  localparam int TO = 5;
  localparam int LM = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_valid, m0_write, m0_lock;
  logic [15:0] m0_addr;
  logic [7:0]  m0_wdata;
  logic        m0_ready, m0_rvalid, m0_err;
  logic [7:0]  m0_rdata;
  logic        m1_valid, m1_write, m1_lock;
  logic [15:0] m1_addr;
  logic [7:0]  m1_wdata;
  logic        m1_ready, m1_rvalid, m1_err;
  logic [7:0]  m1_rdata;
  logic        s_strobe, s_write, s_ack;
  logic [15:0] s_addr;
  logic [7:0]  s_wdata, s_rdata;

  int vectors = 0;
  int miscompares = 0;

  // request-level arbitration state
  int m_last = 1;
  bit m_llock = 1'b0;
  int m_run = 0;

  always #5 clk = ~clk;

  debug_bus_arbiter #(
    .ADDR_W(16), .DATA_W(8), .TIMEOUT(TO), .LOCK_MAX(LM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_write(m0_write),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_ready(m0_ready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_write(m1_write),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_ready(m1_ready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_err(m1_err),
    .s_strobe(s_strobe), .s_write(s_write),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {m0_ready, m1_ready, m0_rvalid, m1_rvalid,
            m0_rdata, m1_rdata, m0_err, m1_err,
            s_strobe, s_write, s_addr, s_wdata};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_last  = 1;
    m_llock = 1'b0;
    m_run   = 0;
  endtask

  // Starts and ends at a negedge while the DUT idles.
  task automatic round(input bit v0, input bit v1,
                       input bit l0, input bit l1,
                       input bit w0, input bit w1,
                       input logic [15:0] a0, input logic [15:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input int dly, input logic [7:0] rd);
    int w;
    bit lw, ww, ack, done;
    int k;
    logic [7:0] erd;
    s_ack = 1'b0;
    chk("idle_strobe", s_strobe, 0);
    chk("idle_rvalid", {m1_rvalid, m0_rvalid}, 0);
    m0_valid = v0; m0_lock = l0; m0_write = w0;
    m0_addr = a0;  m0_wdata = d0;
    m1_valid = v1; m1_lock = l1; m1_write = w1;
    m1_addr = a1;  m1_wdata = d1;
    if (v0 && !v1) w = 0;
    else if (v1 && !v0) w = 1;
    else if (m_llock && m_run < LM) w = m_last;
    else w = 1 - m_last;
    lw = (w == 1) ? l1 : l0;
    ww = (w == 1) ? w1 : w0;
    if (w != m_last || !lw) m_run = 0;
    else if (v0 && v1) m_run++;
    m_last = w;
    m_llock = lw;
    step();
    chk("issue_strobe", s_strobe, 1);
    chk("issue_ready", {m1_ready, m0_ready},
        (w == 1) ? 2'b10 : 2'b01);
    chk("s_addr", s_addr, (w == 1) ? a1 : a0);
    chk("s_write", s_write, ww);
    chk("s_wdata", s_wdata, (w == 1) ? d1 : d0);
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    s_ack = 1'($urandom);
    done = 1'b0;
    k = 0;
    while (!done) begin
      step();
      chk("wait_rvalid", {m1_rvalid, m0_rvalid}, 0);
      chk("wait_strobe", s_strobe, 0);
      s_ack = (k == dly);
      s_rdata = (k == dly) ? rd : 8'($urandom);
      if (k == dly || k == TO - 1) done = 1'b1;
      k++;
    end
    step();
    s_ack = 1'($urandom);
    ack = (dly < TO);
    erd = (ack && !ww) ? rd : 8'h00;
    chk("resp_rvalid", {m1_rvalid, m0_rvalid},
        (w == 1) ? 2'b10 : 2'b01);
    chk("resp_rdata", {m1_rdata, m0_rdata},
        (w == 1) ? {erd, 8'h00} : {8'h00, erd});
    chk("resp_err", {m1_err, m0_err},
        (w == 1) ? {!ack, 1'b0} : {1'b0, !ack});
    chk("resp_ready", {m1_ready, m0_ready}, 0);
    step();
    s_ack = 1'b0;
  endtask

  task automatic stray_ack();
    s_ack = 1'b1;
    s_rdata = 8'($urandom);
    step();
    s_ack = 1'b0;
    chk("stray_strobe", s_strobe, 0);
    chk("stray_rvalid", {m1_rvalid, m0_rvalid}, 0);
    chk("stray_ready", {m1_ready, m0_ready}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    {m0_valid, m0_write, m0_lock} = '0;
    {m1_valid, m1_write, m1_lock} = '0;
    m0_addr = '0; m0_wdata = '0;
    m1_addr = '0; m1_wdata = '0;
    s_ack = 1'b0; s_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_out(), 0);
    rst_n = 1'b1;
    step();

    // single read from m0
    round(1, 0, 0, 0, 0, 0, 16'h0012, 16'h0, 8'h00, 8'h0,
          1, 8'hA5);
    // unlocked contention alternates
    for (int i = 0; i < 4; i++)
      round(1, 1, 0, 0, 0, 1, 16'(i), 16'(16'h100 + i),
            8'(i), 8'(8'h40 + i), 0, 8'(8'h10 + i));
    // m1 write that times out, then m0 served normally
    round(0, 1, 0, 0, 0, 1, 16'h0, 16'h0100, 8'h0, 8'h3C,
          99, 8'hEE);
    round(1, 0, 0, 0, 0, 0, 16'h0020, 16'h0, 8'h0, 8'h0,
          0, 8'h5A);
    // ack on the timeout cycle, then stray acks in idle
    round(1, 0, 0, 0, 0, 0, 16'h0030, 16'h0, 8'h0, 8'h0,
          TO - 1, 8'h77);
    stray_ack();
    stray_ack();
    round(0, 1, 0, 0, 0, 0, 16'h0, 16'h0040, 8'h0, 8'h0,
          2, 8'h99);

    // reset while waiting for an ack
    m0_valid = 1'b1; m0_write = 1'b0; m0_addr = 16'h0050;
    step();
    m0_valid = 1'b0;
    step();
    chk("pre_reset_wait", s_strobe, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_reset_outputs", all_out(), 0);
    model_reset();
    stray_ack();

    // locked streaming by m0 against a waiting m1
    for (int i = 0; i < 4; i++)
      round(1, 1, 1, 0, 0, 0, 16'(16'h200 + i), 16'h0300,
            8'h0, 8'h0, 0, 8'(8'h60 + i));

    for (int i = 0; i < 150; i++) begin
      int vp;
      vp = $urandom_range(1, 3);
      if ($urandom_range(0, 7) == 0) stray_ack();
      round(vp[0], vp[1], 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom),
            16'($urandom), 16'($urandom),
            8'($urandom), 8'($urandom),
            $urandom_range(0, TO + 2), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
